// File: rtl/game_judge.sv
// game_judge: scoring stage behind the game beat counter.
// Samples the ROM note on each beat tick, keeps one judgement window open
// per note onset, matches key presses against it and accumulates
// hit/miss/wrong counts, combo, best combo and a saturating score.
//
// Handshake note: there is no backpressure anywhere in this block. beat_tick
// and key_valid are single-cycle strobes that are always accepted when the
// game is playing; expected_note is qualified by beat_tick and key_code by
// key_valid. result_valid is a one-cycle strobe that qualifies result_code,
// registered one cycle after the triggering input cycle.
module game_judge #(
  parameter int NOTE_W       = 5,
  parameter int WINDOW_BEATS = 2,
  parameter int HIT_PTS      = 10,
  parameter int COMBO_CAP    = 5,
  parameter int CNT_W        = 10,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gamestart,
  input  logic               song_end,
  input  logic               beat_tick,
  input  logic [NOTE_W-1:0]  expected_note,
  input  logic               key_valid,
  input  logic [NOTE_W-1:0]  key_code,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   wrong_cnt,
  output logic [CNT_W-1:0]   combo,
  output logic [CNT_W-1:0]   max_combo,
  output logic               result_valid,
  output logic [1:0]         result_code,
  output logic               window_open,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int BL_W = (WINDOW_BEATS < 1) ? 1 : $clog2(WINDOW_BEATS + 1);

  localparam logic [1:0] RC_NONE  = 2'b00;
  localparam logic [1:0] RC_HIT   = 2'b01;
  localparam logic [1:0] RC_MISS  = 2'b10;
  localparam logic [1:0] RC_WRONG = 2'b11;

  // ARMED = playing with no note pending, OPEN = a note awaits its key.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_OPEN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0]    wrong_q, wrong_d;
  logic [CNT_W-1:0]    combo_q, combo_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic                rv_q, rv_d;
  logic [1:0]          rc_q, rc_d;
  logic                done_q, done_d;
  logic [NOTE_W-1:0]   last_note_q, last_note_d;
  logic [NOTE_W-1:0]   target_q, target_d;
  logic [BL_W-1:0]     bl_q, bl_d;

  // Per-cycle judgement scratch, resolved in evaluation order key/beat/end.
  logic                open_w;
  logic                hit_w;
  logic                wrong_w;
  logic                miss_beat_w;
  logic                miss_end_w;
  logic                onset_w;
  logic [CNT_W-1:0]    bonus_w;
  logic [SCORE_W:0]    score_sum_w;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  // Bonus for a hit is the combo before the hit, capped.
  always_comb begin
    bonus_w     = (combo_q > CNT_W'(COMBO_CAP)) ? CNT_W'(COMBO_CAP) : combo_q;
    score_sum_w = {1'b0, score_q} + (SCORE_W+1)'(HIT_PTS) + (SCORE_W+1)'(bonus_w);
  end

  // Next-state and judgement logic.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    wrong_d     = wrong_q;
    combo_d     = combo_q;
    max_d       = max_q;
    rv_d        = 1'b0;
    rc_d        = RC_NONE;
    done_d      = done_q;
    last_note_d = last_note_q;
    target_d    = target_q;
    bl_d        = bl_q;
    open_w      = 1'b0;
    hit_w       = 1'b0;
    wrong_w     = 1'b0;
    miss_beat_w = 1'b0;
    miss_end_w  = 1'b0;
    onset_w     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gamestart) begin
          state_d     = S_ARMED;
          score_d     = '0;
          hit_d       = '0;
          miss_d      = '0;
          wrong_d     = '0;
          combo_d     = '0;
          max_d       = '0;
          last_note_d = '0;
          target_d    = '0;
          bl_d        = '0;
          done_d      = 1'b0;
        end
      end

      S_ARMED, S_OPEN: begin
        if (!gamestart) begin
          state_d = S_IDLE;
        end else begin
          open_w = (state_q == S_OPEN);

          // Key first: a matching key on an open window hits and closes it.
          if (key_valid) begin
            if (open_w && (key_code == target_q)) begin
              hit_w  = 1'b1;
              open_w = 1'b0;
            end else begin
              wrong_w = 1'b1;
            end
          end

          // Beat second: a new onset replaces (and misses) any pending note;
          // otherwise a pending window ages by one tick.
          if (beat_tick) begin
            onset_w     = (expected_note != '0) && (expected_note != last_note_q);
            last_note_d = expected_note;
            if (onset_w) begin
              miss_beat_w = open_w;
              target_d    = expected_note;
              bl_d        = BL_W'(WINDOW_BEATS);
              open_w      = 1'b1;
            end else if (open_w) begin
              bl_d = bl_q - BL_W'(1);
              if (bl_q <= BL_W'(1)) begin
                miss_beat_w = 1'b1;
                open_w      = 1'b0;
              end
            end
          end

          // End of song last: anything still pending is a miss.
          if (song_end) begin
            miss_end_w = open_w;
            open_w     = 1'b0;
            state_d    = S_DONE;
            done_d     = 1'b1;
          end else begin
            state_d = open_w ? S_OPEN : S_ARMED;
          end

          if (hit_w) begin
            score_d = score_sum_w[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_w[SCORE_W-1:0];
            hit_d   = sat_inc(hit_q);
            combo_d = sat_inc(combo_q);
            if (combo_d > max_q) begin
              max_d = combo_d;
            end
          end
          if (wrong_w) begin
            wrong_d = sat_inc(wrong_q);
            combo_d = '0;
          end
          if (miss_beat_w) begin
            miss_d = sat_inc(miss_d);
          end
          if (miss_end_w) begin
            miss_d = sat_inc(miss_d);
          end
          if (miss_beat_w || miss_end_w) begin
            combo_d = '0;
          end

          rv_d = hit_w || wrong_w || miss_beat_w || miss_end_w;
          if (miss_beat_w || miss_end_w) begin
            rc_d = RC_MISS;
          end else if (hit_w) begin
            rc_d = RC_HIT;
          end else if (wrong_w) begin
            rc_d = RC_WRONG;
          end
        end
      end

      S_DONE: begin
        if (!gamestart) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      wrong_q     <= '0;
      combo_q     <= '0;
      max_q       <= '0;
      rv_q        <= 1'b0;
      rc_q        <= RC_NONE;
      done_q      <= 1'b0;
      last_note_q <= '0;
      target_q    <= '0;
      bl_q        <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      wrong_q     <= wrong_d;
      combo_q     <= combo_d;
      max_q       <= max_d;
      rv_q        <= rv_d;
      rc_q        <= rc_d;
      done_q      <= done_d;
      last_note_q <= last_note_d;
      target_q    <= target_d;
      bl_q        <= bl_d;
    end
  end

  assign score        = score_q;
  assign hit_cnt      = hit_q;
  assign miss_cnt     = miss_q;
  assign wrong_cnt    = wrong_q;
  assign combo        = combo_q;
  assign max_combo    = max_q;
  assign result_valid = rv_q;
  assign result_code  = rc_q;
  assign window_open  = (state_q == S_OPEN);
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_game_judge.sv
// Bench for game_judge: scripted scenarios from the test plan plus a
// saturation run. Each driven cycle pushes its expected {valid, code}
// result; the result is popped and compared one cycle later.
module tb_game_judge;

  localparam logic [2:0] R_NONE  = 3'b000;
  localparam logic [2:0] R_HIT   = 3'b101;
  localparam logic [2:0] R_MISS  = 3'b110;
  localparam logic [2:0] R_WRONG = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic        clk;
  logic        reset;
  logic        gamestart;
  logic        song_end;
  logic        beat_tick;
  logic [4:0]  expected_note;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [15:0] score;
  logic [9:0]  hit_cnt;
  logic [9:0]  miss_cnt;
  logic [9:0]  wrong_cnt;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic        result_valid;
  logic [1:0]  result_code;
  logic        window_open;
  logic        done;
  logic [1:0]  state_dbg;

  logic [2:0] exp_q[$];
  int tests_run;
  int fails;

  game_judge dut (
    .clk(clk), .reset(reset), .gamestart(gamestart), .song_end(song_end),
    .beat_tick(beat_tick), .expected_note(expected_note),
    .key_valid(key_valid), .key_code(key_code),
    .score(score), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .wrong_cnt(wrong_cnt), .combo(combo), .max_combo(max_combo),
    .result_valid(result_valid), .result_code(result_code),
    .window_open(window_open), .done(done), .state_dbg(state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one clock of stimulus, with the expected result queued on entry
  // and popped/compared once the registered result is visible.
  task automatic step(input logic bt, input logic [4:0] note, input logic kv,
                      input logic [4:0] key, input logic se, input logic [2:0] exp);
    logic [2:0] want;
    logic [2:0] got;
    beat_tick     = bt;
    expected_note = note;
    key_valid     = kv;
    key_code      = key;
    song_end      = se;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    beat_tick = 1'b0;
    key_valid = 1'b0;
    song_end  = 1'b0;
    got = {result_valid, result_code};
    tests_run++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL result_queue empty got %b", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL result got %b exp %b (note %0d key %0d) t=%0t", got, want, note, key, $time);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gamestart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({score, hit_cnt, miss_cnt, wrong_cnt, combo, max_combo} !== '0) begin
      fails++; $display("FAIL reset_counters got score %0d hit %0d miss %0d", score, hit_cnt, miss_cnt);
    end
    tests_run++;
    if ({result_valid, result_code, window_open, done, state_dbg} !== 6'd0) begin
      fails++; $display("FAIL reset_flags got %b exp 000000",
                        {result_valid, result_code, window_open, done, state_dbg});
    end
    reset = 1'b0;
    gamestart = 1'b1;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    tests_run++;
    if (state_dbg !== ST_ARMED || score !== 16'd0 || combo !== 10'd0) begin
      fails++; $display("FAIL arm state %0d exp %0d score %0d", state_dbg, ST_ARMED, score);
    end
  endtask

  task automatic test_hit_combo();
    logic [4:0] notes [7];
    int exp_score;
    notes = '{5'd7, 5'd3, 5'd5, 5'd2, 5'd9, 5'd4, 5'd6};
    exp_score = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, notes[i], 1'b0, 5'd0, 1'b0, R_NONE);
      tests_run++;
      if (window_open !== 1'b1) begin
        fails++; $display("FAIL open_on_onset got %b exp 1 note %0d", window_open, notes[i]);
      end
      step(1'b0, 5'd0, 1'b1, notes[i], 1'b0, R_HIT);
      exp_score += 10 + ((i < 5) ? i : 5);
      tests_run++;
      if (score !== 16'(exp_score) || combo !== 10'(i + 1) || window_open !== 1'b0) begin
        fails++; $display("FAIL hit_step%0d score %0d exp %0d combo %0d exp %0d open %b",
                          i, score, exp_score, combo, i + 1, window_open);
      end
    end
    tests_run++;
    if (score !== 16'd90 || hit_cnt !== 10'd7 || max_combo !== 10'd7) begin
      fails++; $display("FAIL combo_total score %0d exp 90 hits %0d exp 7 max %0d exp 7",
                        score, hit_cnt, max_combo);
    end
  endtask

  task automatic test_miss_sustain();
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_NONE);
    tests_run++;
    if (window_open !== 1'b1 || miss_cnt !== 10'd0) begin
      fails++; $display("FAIL sustain_first open %b exp 1 miss %0d exp 0", window_open, miss_cnt);
    end
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_MISS);
    tests_run++;
    if (miss_cnt !== 10'd1 || combo !== 10'd0 || window_open !== 1'b0 || state_dbg !== ST_ARMED) begin
      fails++; $display("FAIL sustain_miss miss %0d exp 1 combo %0d exp 0 open %b state %0d",
                        miss_cnt, combo, window_open, state_dbg);
    end
  endtask

  task automatic test_wrong_then_hit();
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b0, 5'd0, 1'b1, 5'd3, 1'b0, R_WRONG);
    tests_run++;
    if (wrong_cnt !== 10'd1 || combo !== 10'd0 || window_open !== 1'b1) begin
      fails++; $display("FAIL wrong wrong %0d exp 1 combo %0d exp 0 open %b exp 1",
                        wrong_cnt, combo, window_open);
    end
    step(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, R_HIT);
    tests_run++;
    if (score !== 16'd100 || hit_cnt !== 10'd8 || combo !== 10'd1 || max_combo !== 10'd7) begin
      fails++; $display("FAIL late_hit score %0d exp 100 hits %0d exp 8 combo %0d max %0d",
                        score, hit_cnt, combo, max_combo);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_NONE);
    // Key hits the old note in the same cycle as a new onset.
    step(1'b1, 5'd5, 1'b1, 5'd7, 1'b0, R_HIT);
    tests_run++;
    if (score !== 16'd111 || miss_cnt !== 10'd1 || window_open !== 1'b1 || combo !== 10'd2) begin
      fails++; $display("FAIL hit_and_onset score %0d exp 111 miss %0d exp 1 open %b combo %0d exp 2",
                        score, miss_cnt, window_open, combo);
    end
    // Onsets arriving while a note is pending miss it and re-open.
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_MISS);
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, R_MISS);
    tests_run++;
    if (miss_cnt !== 10'd3 || window_open !== 1'b1 || combo !== 10'd0) begin
      fails++; $display("FAIL onset_miss miss %0d exp 3 open %b exp 1 combo %0d", miss_cnt, window_open, combo);
    end
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, R_HIT);
    tests_run++;
    if (score !== 16'd121 || hit_cnt !== 10'd10) begin
      fails++; $display("FAIL target5_hit score %0d exp 121 hits %0d exp 10", score, hit_cnt);
    end
  endtask

  task automatic test_song_end();
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, R_MISS);
    tests_run++;
    if (done !== 1'b1 || miss_cnt !== 10'd4 || window_open !== 1'b0 || state_dbg !== ST_DONE) begin
      fails++; $display("FAIL song_end done %b miss %0d exp 4 open %b state %0d", done, miss_cnt, window_open, state_dbg);
    end
    step(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, R_NONE);
    tests_run++;
    if (score !== 16'd121 || hit_cnt !== 10'd10 || wrong_cnt !== 10'd1 || window_open !== 1'b0) begin
      fails++; $display("FAIL frozen score %0d hits %0d wrong %0d open %b", score, hit_cnt, wrong_cnt, window_open);
    end
    gamestart = 1'b0;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    tests_run++;
    if (done !== 1'b0 || state_dbg !== ST_IDLE || score !== 16'd121 || miss_cnt !== 10'd4 || max_combo !== 10'd7) begin
      fails++; $display("FAIL to_idle done %b state %0d score %0d miss %0d max %0d",
                        done, state_dbg, score, miss_cnt, max_combo);
    end
    step(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, R_NONE);
    tests_run++;
    if (hit_cnt !== 10'd10 || wrong_cnt !== 10'd1) begin
      fails++; $display("FAIL idle_hold hits %0d exp 10 wrong %0d exp 1", hit_cnt, wrong_cnt);
    end
  endtask

  task automatic test_reset_mid();
    gamestart = 1'b1;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    tests_run++;
    if (state_dbg !== ST_ARMED || score !== 16'd0 || hit_cnt !== 10'd0 || miss_cnt !== 10'd0 ||
        wrong_cnt !== 10'd0 || max_combo !== 10'd0) begin
      fails++; $display("FAIL restart_clear state %0d score %0d hits %0d miss %0d max %0d",
                        state_dbg, score, hit_cnt, miss_cnt, max_combo);
    end
    step(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, R_NONE);
    step(1'b0, 5'd0, 1'b1, 5'd1, 1'b0, R_HIT);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i % 2 == 0) ? 5'd2 : 5'd1, 1'b0, 5'd0, 1'b0, R_NONE);
      step(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, R_WRONG);
      step(1'b0, 5'd0, 1'b1, (i % 2 == 0) ? 5'd2 : 5'd1, 1'b0, R_HIT);
    end
    tests_run++;
    if (score !== 16'd40 || wrong_cnt !== 10'd3) begin
      fails++; $display("FAIL pre_reset score %0d exp 40 wrong %0d exp 3", score, wrong_cnt);
    end
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, R_NONE);
    reset = 1'b1;
    #2;
    tests_run++;
    if ({score, hit_cnt, wrong_cnt, combo, max_combo, window_open, state_dbg} !== '0) begin
      fails++; $display("FAIL async_reset score %0d hits %0d open %b state %0d", score, hit_cnt, window_open, state_dbg);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, R_NONE);
    for (int i = 0; i < 4400; i++) begin
      step(1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, 1'b0, 5'd0, 1'b0, R_NONE);
      step(1'b0, 5'd0, 1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, 1'b0, R_HIT);
    end
    tests_run++;
    if (score !== 16'hFFFF) begin
      fails++; $display("FAIL score_sat got %0d exp 65535", score);
    end
    tests_run++;
    if (hit_cnt !== 10'h3FF || combo !== 10'h3FF || max_combo !== 10'h3FF) begin
      fails++; $display("FAIL cnt_sat hits %0d combo %0d max %0d exp 1023", hit_cnt, combo, max_combo);
    end
    // A random wrong key resets the saturated combo but keeps the best.
    step(1'b0, 5'd0, 1'b1, 5'($urandom_range(3, 31)), 1'b0, R_WRONG);
    tests_run++;
    if (combo !== 10'd0 || max_combo !== 10'h3FF || score !== 16'hFFFF) begin
      fails++; $display("FAIL sat_wrong combo %0d max %0d score %0d", combo, max_combo, score);
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    reset = 1'b1;
    gamestart = 1'b0;
    song_end = 1'b0;
    beat_tick = 1'b0;
    expected_note = '0;
    key_valid = 1'b0;
    key_code = '0;
    test_reset();
    test_hit_combo();
    test_miss_sustain();
    test_wrong_then_hit();
    test_back_to_back();
    test_song_end();
    test_reset_mid();
    test_saturation();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/game_judge.md
Name: game_judge

Overview:
- Scoring stage directly downstream of the beat/song-position counter in game mode.
- On each game beat it samples the expected note, which the music ROM looks up from the current game beat index, and opens a timed judgement window for each new note.
- It matches decoded key presses against that note and accumulates hit/miss/wrong counts, combo and score.
- Results drive the 7-segment/LED score display and the end-of-song summary.

Parameters:
- NOTE_W, 5, width of note codes; code 0 = rest.
- WINDOW_BEATS, 2, number of beat ticks a note window stays open; must be ≥1.
- HIT_PTS, 10, base points per hit.
- COMBO_CAP, 5, maximum combo bonus added per hit.
- CNT_W, 10, width of hit/miss/wrong/combo counters.
- SCORE_W, 16, score width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- gamestart  input  1  game mode running (level).
- song_end  input  1  high once the game beat counter has saturated at the last beat (level).
- beat_tick  input  1  one-cycle pulse in the cycle the game beat advances.
- expected_note  input  NOTE_W  ROM note for the current game beat; valid whenever beat_tick is high.
- key_valid  input  1  one-cycle pulse for a new key press.
- key_code  input  NOTE_W  note code of the pressed key; qualified by key_valid.
- score  output  SCORE_W  accumulated score.
- hit_cnt  output  CNT_W  number of hits.
- miss_cnt  output  CNT_W  number of misses.
- wrong_cnt  output  CNT_W  number of wrong or unexpected presses.
- combo  output  CNT_W  current consecutive-hit count.
- max_combo  output  CNT_W  best combo this game.
- result_valid  output  1  one-cycle pulse: a judgement occurred this cycle.
- result_code  output  2  01 HIT, 10 MISS, 11 WRONG, 00 none.
- window_open  output  1  a note is awaiting a key press.
- done  output  1  song finished, results frozen.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - All outputs 0.
  - last_note = 0, target = 0, beats_left = 0.
- All outputs are registered; every judgement is visible on the outputs 1 cycle after the triggering input cycle.
- State IDLE:
  - Counters hold their previous values.
  - When gamestart = 1: go to ARMED, and clear score, all counters, combo, max_combo and last_note in that same transition.
- States ARMED and OPEN (playing):
  - gamestart = 0 → IDLE immediately. No judgement is made; counters hold.
  - window_open = 1 exactly when state is OPEN.
- Evaluation order within one cycle: key first, then beat, then song_end.
- Key evaluation (when key_valid = 1):
  - State OPEN and key_code == target → HIT:
    - score += HIT_PTS + min(combo_old, COMBO_CAP).
    - hit_cnt += 1; combo += 1; max_combo = max(max_combo, new combo).
    - Window closes.
  - Otherwise (key in ARMED, or mismatch in OPEN) → WRONG:
    - wrong_cnt += 1; combo = 0.
    - The window stays open and may still be hit later.
- Beat evaluation (when beat_tick = 1):
  - note = expected_note; onset = (note != 0) && (note != last_note); last_note = note on every tick.
  - If the window is still open after key evaluation and onset = 1: MISS for the old note (miss_cnt += 1, combo = 0). Then target = note, beats_left = WINDOW_BEATS, state OPEN.
  - Else if onset = 1: open a new window the same way.
  - Else if the window is still open: beats_left -= 1. If it reaches 0 → MISS and go to ARMED.
  - A same-cycle HIT on the old target closes that window first, so no MISS is recorded for it.
- song_end = 1 while playing:
  - A still-open window after key/beat evaluation → MISS.
  - State → DONE; done = 1. Further key_valid and beat_tick are ignored.
- State DONE: gamestart = 0 → IDLE with done = 0; counters hold for display.
- result_code priority when several events occur in one cycle: MISS > HIT > WRONG. All counters still update for every event.
- Saturation:
  - Score saturates at 2^SCORE_W − 1.
  - Every CNT_W counter saturates at all-ones; saturation never wraps.
- A repeated identical note on consecutive beats is a sustain, not a new onset. A rest (code 0) between two equal notes makes the second one a new onset.

Test Plan:
- Reset mid-game with score = 40 → next cycle all outputs 0, IDLE; gamestart high → ARMED with counters 0.
- Beat with note 7, key 7 one cycle later → result HIT, score 10, hit_cnt 1, combo 1, window_open 0. Repeat for notes 3, 5, 2, 9, 4, 6 → combo 7, score 10+11+12+13+14+15+15 = 90 (bonus capped at 5).
- Note 7 opens, no key for 2 beat ticks carrying note 7 (sustain) → MISS on the 2nd tick, miss_cnt 1, combo 0.
- Note 7 open, key 3 → WRONG, wrong_cnt 1, combo 0, window still open; then key 7 → HIT with score +10.
- Same cycle: key 7 hits open note 7 and beat_tick brings onset note 5 → HIT only, miss_cnt unchanged, window_open 1 with target 5. Repeat without the key → MISS, new window opens for 5.
- Note 7 open when song_end rises → MISS, done 1; later key_valid ignored; gamestart low → IDLE, done 0, counters held.
